// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF/ID instruction queue: reset polarity, stall
// encoding and the position of the decode stall bit in the pipeline stall vector.
package if_id_buffer_pkg;

    localparam logic RST_ACTIVE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NOT_STOP   = 1'b0;
    localparam int   STALL_W    = 6;
    localparam int   STALL_ID   = 2;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_id_ram.sv
// DEPTH x WIDTH register file for the IF/ID queue: one clocked write port and
// one asynchronous read port. Contents are not reset.
module if_id_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling queue: fetch keeps enqueuing while decode stalls; decode
// sees an all-zero bubble whenever the queue is empty.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SIDE_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   if_valid,
    input  logic [ADDR_W-1:0]      if_pc,
    input  logic [DATA_W-1:0]      if_inst,
    input  logic [SIDE_W-1:0]      if_side,
    output logic                   if_ready,
    output logic                   id_valid,
    output logic [ADDR_W-1:0]      id_pc,
    output logic [DATA_W-1:0]      id_inst,
    output logic [SIDE_W-1:0]      id_side,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W + SIDE_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_enq;
    logic             w_deq;
    logic [ENT_W-1:0] w_wdata;
    logic [ENT_W-1:0] w_rdata;
    logic             w_unused_stall;

    // Only the decode stall bit matters to this stage.
    assign w_unused_stall = ^{stall[STALL_W-1:STALL_ID+1], stall[STALL_ID-1:0]};

    assign if_ready = (r_count != FULL_CNT);
    assign id_valid = (r_count != '0);
    assign count    = r_count;

    assign w_enq = if_valid & if_ready & ~flush;
    assign w_deq = id_valid & (stall[STALL_ID] == NOT_STOP) & ~flush;

    assign w_wdata = {if_pc, if_inst, if_side};

    if_id_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_enq),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    always_comb begin
        {id_pc, id_inst, id_side} = '0;
        if (id_valid) begin
            {id_pc, id_inst, id_side} = w_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
